// File: rtl/imem_controller.sv
// -----------------------------------------------------------------------------
// imem_controller
//
// Owns the single-port instruction memory array. After reset it zero-fills
// the array one word per cycle. Once the fill is done, it shares the array
// each cycle between the core fetch port (read) and the program loader
// (write). The loader has fixed priority. A burst counter stops the loader
// from starving fetch: after MAX_LD_BURST consecutive loader grants while a
// fetch is pending, the fetch wins. Fetch data is registered and returned one
// cycle after the grant.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   fetch_req/addr     core read request, byte address
//   fetch_gnt          fetch accepted this cycle (combinational)
//   fetch_rvalid       registered response valid, with fetch_rdata/fetch_fault
//   ld_req/addr/wdata  loader write request, word address, data
//   ld_gnt             loader write accepted this cycle (combinational)
//   init_done          high once the zero-fill has completed
//   mem_addr/wdata/we  array controls (array writes at posedge clk)
//   mem_rdata          combinational array read data at mem_addr
// -----------------------------------------------------------------------------
module imem_controller #(
  parameter int DEPTH        = 1024,
  parameter int AW           = 10,
  parameter int MAX_LD_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_fault,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  output logic          init_done,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  localparam int            BW        = $clog2(MAX_LD_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_LD_BURST);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clear_ptr;
  logic [BW-1:0] burst_cnt;
  logic          fault_p0;

  // A fetch is bad when it is not word aligned or points past the array.
  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  // Counter increment that sticks at the guard limit.
  function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
    return (v == BURST_MAX) ? v : v + BW'(1);
  endfunction

  assign fault_p0 = addr_fault(fetch_addr);

  // Stage p0: arbitration and array control
  always_comb begin
    state_nxt = state;
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = fetch_addr[AW+1:2];
    mem_wdata = 32'd0;
    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clear_ptr;
        if (clear_ptr == LAST_WORD) state_nxt = RUN;
      end
      RUN: begin
        // The loader yields only when fetch has already lost MAX_LD_BURST times.
        if (ld_req && !(fetch_req && burst_cnt == BURST_MAX)) begin
          ld_gnt    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_wdata;
        end else if (fetch_req) begin
          fetch_gnt = 1'b1;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Stage p1: registered control and fetch response
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLEAR;
      clear_ptr    <= '0;
      burst_cnt    <= '0;
      init_done    <= 1'b0;
      fetch_rvalid <= 1'b0;
      fetch_rdata  <= 32'd0;
      fetch_fault  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clear_ptr <= clear_ptr + AW'(1);
        if (clear_ptr == LAST_WORD) init_done <= 1'b1;
      end
      if (state == RUN) begin
        if (!fetch_req || fetch_gnt) burst_cnt <= '0;
        else if (ld_gnt)             burst_cnt <= sat_inc(burst_cnt);
      end
      fetch_rvalid <= fetch_gnt;
      if (fetch_gnt) begin
        fetch_fault <= fault_p0;
        fetch_rdata <= fault_p0 ? 32'd0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_controller.sv
// -----------------------------------------------------------------------------
// tb_imem_controller
//
// Drives the controller against a behavioural instruction array. A reference
// model predicts the arbitration outcome every cycle and queues the expected
// fetch response. A separate monitor pops that queue whenever the DUT
// presents fetch_rvalid.
// -----------------------------------------------------------------------------
module tb_imem_controller;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int MAXB  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          fetch_fault;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;
  logic          init_done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  imem_controller #(.DEPTH(DEPTH), .AW(AW), .MAX_LD_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_fault(fetch_fault),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .init_done(init_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] arr     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) if (mem_we) arr[mem_addr] = mem_wdata;
  assign mem_rdata = arr[mem_addr];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        fault;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  bit   run_chk = 1'b0;
  bit   mon_en  = 1'b0;
  int   wait_n  = 0;

  // Reference model: loader wins unless fetch has already lost MAXB times in a row.
  always @(negedge clk) begin
    if (run_chk) begin
      bit   exp_l, exp_f, bad;
      exp_t e;
      exp_l = ld_req && !(fetch_req && wait_n == MAXB);
      exp_f = fetch_req && !exp_l;
      chk(ld_gnt == exp_l && fetch_gnt == exp_f, "grant", {62'b0, fetch_gnt, ld_gnt}, {62'b0, exp_f, exp_l});
      if (exp_l) ref_mem[ld_addr] = ld_wdata;
      if (exp_f) begin
        bad    = (fetch_addr % 4 != 0) || (fetch_addr >= 4 * DEPTH);
        e.cyc  = cyc;
        e.fault = bad;
        e.data = bad ? 32'd0 : ref_mem[fetch_addr / 4];
        q.push_back(e);
      end
      if (!fetch_req || exp_f) wait_n = 0;
      else if (exp_l)          wait_n = wait_n + 1;
    end
  end

  // Monitor: each response must appear exactly one cycle after its grant.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   due;
      exp_t e;
      due = (q.size() > 0) && (q[0].cyc == cyc - 1);
      if (fetch_rvalid && due) begin
        e = q.pop_front();
        chk(fetch_fault == e.fault && fetch_rdata == e.data, "fetch_resp",
            {31'b0, fetch_fault, fetch_rdata}, {31'b0, e.fault, e.data});
      end else if (fetch_rvalid) begin
        chk(1'b0, "rvalid_spurious", 64'd1, 64'd0);
      end else if (due) begin
        e = q.pop_front();
        chk(1'b0, "rvalid_missing", 64'd0, 64'd1);
      end
    end
  end

  task automatic fill_check(input int n, input bit expect_done);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(!init_done && mem_we && mem_wdata == 32'd0 && mem_addr == AW'(i) && !fetch_gnt && !ld_gnt,
          "clear_cycle", {20'b0, init_done, mem_we, fetch_gnt, ld_gnt, 30'b0, mem_addr},
          {20'b0, 4'b0100, 30'b0, AW'(i)});
      @(posedge clk); #1;
    end
    fetch_req = 1'b0;
    ld_req    = 1'b0;
    if (expect_done) begin
      @(negedge clk);
      chk(init_done == 1'b1, "init_done_rise", {63'b0, init_done}, 64'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic ld_write(input logic [AW-1:0] a, input logic [31:0] d);
    bit g = 1'b0;
    int n = 0;
    ld_req = 1'b1; ld_addr = a; ld_wdata = d;
    while (!g && n < 20) begin
      @(negedge clk); g = ld_gnt; n++;
      @(posedge clk); #1;
    end
    ld_req = 1'b0;
    chk(g, "ld_grant_timeout", {63'b0, g}, 64'd1);
  endtask

  task automatic fetch_once(input logic [31:0] a, output logic rv, output logic [31:0] rd, output logic ft);
    bit g = 1'b0;
    int n = 0;
    fetch_req = 1'b1; fetch_addr = a;
    while (!g && n < 20) begin
      @(negedge clk); g = fetch_gnt; n++;
      @(posedge clk); #1;
    end
    fetch_req = 1'b0;
    chk(g, "fetch_grant_timeout", {63'b0, g}, 64'd1);
    @(negedge clk);
    rv = fetch_rvalid; rd = fetch_rdata; ft = fetch_fault;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_faddr();
    int          r = $urandom_range(0, 9);
    logic [31:0] a = 32'($urandom_range(0, 31)) * 4;
    if (r == 7 || r == 9) a = a + 32'($urandom_range(1, 3));
    if (r == 8 || r == 9) a = a | (32'h1000 << $urandom_range(0, 19));
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        rv, ft;
    logic [31:0] rd;
    logic [11:0] pat;
    logic [31:0] w [0:2];
    bit          lg, fg;
    int          bad_words;

    for (int i = 0; i < DEPTH; i++) begin
      arr[i]     = 32'hA5A5_0000 | 32'(i);
      ref_mem[i] = 32'd0;
    end
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = 32'd0;
    ld_req = 1'b0; ld_addr = '0; ld_wdata = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk(!init_done && !fetch_rvalid && fetch_rdata == 32'd0 && !fetch_fault, "reset_state",
        {30'b0, init_done, fetch_rvalid, fetch_rdata}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Requests held high during the fill must not be granted.
    fetch_req = 1'b1; fetch_addr = 32'h14; ld_req = 1'b1; ld_addr = 10'd3; ld_wdata = 32'hFFFF_FFFF;
    fill_check(DEPTH, 1'b1);
    wait_n = 0; run_chk = 1'b1; mon_en = 1'b1;

    ld_write(10'd5, 32'h0050_0093);
    fetch_once(32'h14, rv, rd, ft);
    chk(rv && rd == 32'h0050_0093 && !ft, "wr_then_rd", {31'b0, rv, rd}, {31'b0, 1'b1, 32'h0050_0093});

    fetch_once(32'h16, rv, rd, ft);
    chk(rv && ft && rd == 32'd0, "misaligned", {30'b0, rv, ft, rd}, {30'b0, 2'b11, 32'd0});
    fetch_once(32'h1000, rv, rd, ft);
    chk(rv && ft && rd == 32'd0, "out_of_range", {30'b0, rv, ft, rd}, {30'b0, 2'b11, 32'd0});
    chk(arr[5] == 32'h0050_0093 && arr[0] == 32'd0, "faults_no_write", {arr[5], arr[0]}, {32'h0050_0093, 32'd0});

    // Loader and fetch contend: expect LLLLF repeating.
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 32'h18; ld_req = 1'b1; ld_addr = 10'd7; ld_wdata = 32'h1234_5678;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      pat[11-k] = ld_gnt;
      chk(!(ld_gnt && fetch_gnt) && (ld_gnt || fetch_gnt), "one_grant", {62'b0, fetch_gnt, ld_gnt}, 64'd1);
      @(posedge clk); #1;
    end
    fetch_req = 1'b0; ld_req = 1'b0;
    chk(pat == 12'b1111_0111_1011, "burst_pattern", {52'b0, pat}, {52'b0, 12'b1111_0111_1011});

    // Back-to-back fetches of freshly loaded words.
    w[0] = 32'h1111_0001; w[1] = 32'h2222_0002; w[2] = 32'h3333_0003;
    for (int k = 0; k < 3; k++) ld_write(AW'(k), w[k]);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) chk(fetch_gnt, "b2b_gnt", {63'b0, fetch_gnt}, 64'd1);
      if (k > 0) chk(fetch_rvalid && fetch_rdata == w[k-1], "b2b_rvalid",
                     {31'b0, fetch_rvalid, fetch_rdata}, {31'b0, 1'b1, w[k-1]});
      @(posedge clk); #1;
      if (k < 2) fetch_addr = 32'(4 * (k + 1));
      else       fetch_req = 1'b0;
    end

    // Randomized traffic; a requester holds its inputs until granted.
    lg = 1'b0; fg = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!ld_req || lg) begin
        ld_req = ($urandom_range(0, 2) == 0);
        ld_addr = AW'($urandom_range(0, 31));
        ld_wdata = $urandom;
      end
      if (!fetch_req || fg) begin
        fetch_req = ($urandom_range(0, 1) == 0);
        fetch_addr = rand_faddr();
      end
      @(negedge clk); lg = ld_gnt; fg = fetch_gnt;
      @(posedge clk); #1;
    end
    ld_req = 1'b0; fetch_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    bad_words = 0;
    for (int i = 0; i < DEPTH; i++) if (arr[i] !== ref_mem[i]) bad_words++;
    chk(bad_words == 0, "array_contents", 64'(bad_words), 64'd0);
    chk(q.size() == 0, "queue_drained", 64'(q.size()), 64'd0);

    // Reset while a fetch is being granted drops its response.
    run_chk = 1'b0; mon_en = 1'b0;
    q.delete();
    fetch_req = 1'b1; fetch_addr = 32'h0; reset = 1'b1;
    @(negedge clk);
    chk(fetch_gnt, "gnt_before_reset", {63'b0, fetch_gnt}, 64'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    chk(!fetch_rvalid && !init_done && fetch_rdata == 32'd0, "rvalid_dropped",
        {30'b0, fetch_rvalid, init_done, fetch_rdata}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset mid-fill at word 500 restarts from word 0.
    fill_check(500, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk(mem_addr == 10'd500 && !init_done, "midfill_ptr", {53'b0, init_done, mem_addr}, {54'b0, 10'd500});
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    fill_check(DEPTH, 1'b1);

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    wait_n = 0; run_chk = 1'b1; mon_en = 1'b1;
    fetch_once(32'h14, rv, rd, ft);
    chk(rv && rd == 32'd0 && !ft, "refilled_zero", {30'b0, rv, ft, rd}, {30'b0, 2'b10, 32'd0});
    repeat (2) @(posedge clk);
    #1;
    bad_words = 0;
    for (int i = 0; i < DEPTH; i++) if (arr[i] !== 32'd0) bad_words++;
    chk(bad_words == 0, "refill_contents", 64'(bad_words), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_controller.md
Name: imem_controller

Overview:
Sequences and shares the single-port instruction memory array. After reset it zero-fills the array one word per cycle, then arbitrates each cycle between the core's fetch port (read) and a program-loader port (write). Loader has fixed priority, bounded by a starvation guard for fetch. Fetch read data is registered and returned one cycle after grant.

Parameters:
DEPTH, 1024, number of 32-bit words in the instruction array (power of two)
AW, 10, word-address width, equal to log2(DEPTH)
MAX_LD_BURST, 4, max consecutive loader grants while fetch_req is pending before fetch must win

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
fetch_req  in  1  core requests an instruction read this cycle
fetch_addr  in  32  byte address of the instruction
fetch_gnt  out  1  fetch request accepted this cycle (combinational)
fetch_rvalid  out  1  fetch_rdata/fetch_fault valid (registered)
fetch_rdata  out  32  instruction word
fetch_fault  out  1  accepted fetch was misaligned or out of range
ld_req  in  1  loader requests a word write
ld_addr  in  AW  word address to write
ld_wdata  in  32  write data
ld_gnt  out  1  loader write accepted this cycle (combinational)
init_done  out  1  high once zero-fill is complete
mem_addr  out  AW  word address to the array
mem_wdata  out  32  write data to the array
mem_we  out  1  array write enable (written at posedge clk)
mem_rdata  in  32  combinational read data from the array at mem_addr

Behaviour:
- Reset: synchronous, active-high. On any posedge clk with reset=1: state<=CLEAR, clear_ptr<=0, burst_cnt<=0, fetch_rvalid<=0, fetch_rdata<=0, fetch_fault<=0, init_done<=0. Reset mid-fill or mid-fetch restarts the fill from word 0; an in-flight rvalid is dropped.
- States: CLEAR, RUN. No other states.
- CLEAR: mem_we=1, mem_addr=clear_ptr, mem_wdata=0; clear_ptr increments each cycle. At clear_ptr==DEPTH-1 the write still occurs, then state<=RUN, init_done<=1. Fill takes exactly DEPTH cycles after reset deasserts. fetch_gnt=ld_gnt=0 throughout CLEAR.
- RUN arbitration (combinational, per cycle):
  - ld_req && !(fetch_req && burst_cnt==MAX_LD_BURST) -> ld_gnt=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata.
  - otherwise fetch_req -> fetch_gnt=1, mem_we=0, mem_addr=fetch_addr[AW+1:2].
  - neither: mem_we=0, mem_addr=fetch_addr[AW+1:2], mem_wdata=0.
  - ld_gnt and fetch_gnt are never both 1.
- Starvation guard: burst_cnt increments on a loader grant while fetch_req=1 (saturating at MAX_LD_BURST); resets to 0 on any fetch grant or any cycle fetch_req=0.
- Fetch response: on a fetch grant, next cycle fetch_rvalid=1 with
  - fault = (fetch_addr[1:0]!=0) || (fetch_addr[31:AW+2]!=0);
  - fetch_rdata = fault ? 0 : mem_rdata sampled in the grant cycle; fetch_fault = fault.
  - Cycle without a fetch grant: fetch_rvalid<=0; fetch_rdata and fetch_fault hold.
- Back-to-back grants give back-to-back rvalid. No buffering; a non-granted requester holds its inputs and retries.
- Write then read of the same address: a fetch granted the cycle after a loader write returns the new data.
- init_done stays 1 until next reset.

Test Plan:
- Reset 2 cycles, release, idle -> init_done=0 for exactly 1024 cycles, then 1; mem_we=1 with mem_wdata=0 each CLEAR cycle, mem_addr 0..1023; no grants during CLEAR.
- After init, ld write addr 5 = 0x00500093, then fetch_addr=0x14 -> fetch_gnt same cycle; next cycle fetch_rvalid=1, fetch_rdata=0x00500093, fetch_fault=0.
- fetch_addr=0x16 and separately fetch_addr=0x1000 -> rvalid=1, fetch_fault=1, fetch_rdata=0; array contents unchanged.
- ld_req and fetch_req held high together for 12 cycles -> grant pattern LLLLF repeated (4 loader, 1 fetch); never both grants in one cycle.
- Assert reset at clear_ptr=500, release -> fill restarts at mem_addr 0, init_done rises 1024 cycles after release.
- Continuous fetch 0x0,0x4,0x8 with no loader -> fetch_gnt=1 each cycle, rvalid=1 on three consecutive cycles with matching words.
